// File: rtl/serial_pkg.sv
// Shared state encoding, default idle level and index-width helper for the serial PISO transmitter.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    GAP   = 2'd3
  } tx_state_e;

  localparam logic IDLE_LEVEL_DEF = 1'b0;

  function automatic int idx_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Loadable left-shift register; the MSB tap is the transmitted bit, load wins over shift.
module piso_shreg
  import serial_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_en_i,
  input  logic [WIDTH-1:0] load_dat_i,
  input  logic             shift_en_i,
  input  logic             ser_in_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_en_i) begin
      sh_d = load_dat_i;
    end else if (shift_en_i) begin
      sh_d = {sh_q[WIDTH-2:0], ser_in_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign msb_o = sh_q[WIDTH-1];

endmodule

// File: rtl/serial_piso_tx.sv
// MSB-first PISO transmitter with valid/ready load, GAP_CYCLES idle gap and registered frame flags.
// Optional even-parity trailer cycle when PARITY_EN is defined.
module serial_piso_tx
  import serial_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter int   GAP_CYCLES = 1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              load_data,
  input  logic                          load_valid,
  output logic                          load_ready,
  output logic                          ser_out,
  output logic                          ser_active,
  output logic [idx_width(WIDTH)-1:0]   bit_idx,
  output logic                          frame_done
);

  localparam int IW = idx_width(WIDTH);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_MSB  = IW'(WIDTH - 1);
  localparam logic          GAP_NONE = (GAP_CYCLES == 0);
`ifdef PARITY_EN
  localparam logic HAS_PAR = 1'b1;
`else
  localparam logic HAS_PAR = 1'b0;
`endif

  tx_state_e       state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            active_q, active_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;
  logic            hs;
  logic            start;
  logic            end_frame;
  logic            load_en;
  logic            shift_en;
  logic            shift_in;
  logic            msb;

  assign hs = load_valid && ready_q;

`ifdef PARITY_EN
  // Parity is shifted in behind the word, so it reaches the MSB tap exactly on the PAR cycle.
  logic par_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (load_en) begin
      par_q <= ^load_data;
    end
  end
  assign shift_in = par_q;
`else
  assign shift_in = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    active_d  = 1'b0;
    done_d    = 1'b0;
    ready_d   = 1'b0;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    start     = 1'b0;
    end_frame = 1'b0;

    case (state_q)
      IDLE: begin
        if (hs) begin
          start = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (idx_q != '0) begin
          idx_d    = idx_q - IW'(1);
          active_d = 1'b1;
          if (idx_q == IW'(1) && !HAS_PAR) begin
            done_d  = 1'b1;
            ready_d = GAP_NONE;
          end
        end else if (HAS_PAR) begin
          state_d  = PAR;
          active_d = 1'b1;
          done_d   = 1'b1;
          ready_d  = GAP_NONE;
        end else begin
          end_frame = 1'b1;
        end
      end
      PAR: begin
        end_frame = 1'b1;
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A handshake on the last frame cycle chains straight into the next frame.
    if (end_frame) begin
      idx_d = '0;
      if (hs) begin
        start = 1'b1;
      end else if (!GAP_NONE) begin
        state_d = GAP;
        gap_d   = GAP_LAST;
      end else begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    end

    if (start) begin
      state_d  = SHIFT;
      idx_d    = IDX_MSB;
      active_d = 1'b1;
      load_en  = 1'b1;
      ready_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      gap_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      active_q <= active_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  piso_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_en_i  (load_en),
    .load_dat_i (load_data),
    .shift_en_i (shift_en),
    .ser_in_i   (shift_in),
    .msb_o      (msb)
  );

  assign ser_out    = active_q ? msb : IDLE_LEVEL;
  assign ser_active = active_q;
  assign bit_idx    = idx_q;
  assign frame_done = done_q;
  assign load_ready = ready_q;

endmodule
